// File: rtl/imem_loader.sv
// imem_loader: writer side of the RV32I instruction memory.
//
// Receives a framed byte stream over a valid/ready handshake, assembles
// little-endian 32-bit words and issues one-cycle write strobes into the
// instruction memory. The core is held in reset while loading and is released
// only after a load whose XOR checksum matches.
//
// Frame: 4 length bytes (word count N, LSB first), 4*N payload bytes (each word
// LSB first), 1 checksum byte (XOR of all payload bytes).
//
// Ports:
//   c           system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE/ERR)
//   byte_valid  host presents byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (LEN/DATA/CSUM only)
//   mem_we      instruction memory write strobe, one cycle per word
//   mem_addr    word-aligned byte address of the write
//   mem_wdata   write data
//   core_rst    high keeps the core in reset
//   done        load completed with a good checksum
//   error       load rejected
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        c,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e      state_q;
    logic [1:0]  byte_cnt_q;    // byte lane within the current 32-bit field
    logic [31:0] len_q;
    logic [31:0] word_q;        // assembly buffer, separate from the write register
    logic [31:0] word_idx_q;
    logic [7:0]  xor_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        core_rst_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic [31:0] len_full;
    logic [31:0] word_full;
    logic [31:0] word_idx_inc;

    assign byte_ready   = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign accept       = byte_valid && byte_ready;
    // The 4th byte completes the field in the same cycle it is accepted.
    assign len_full     = {byte_data, len_q[23:0]};
    assign word_full    = {byte_data, word_q[23:0]};
    assign word_idx_inc = word_idx_q + 32'd1;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 2'd0;
            len_q       <= 32'd0;
            word_q      <= 32'd0;
            word_idx_q  <= 32'd0;
            xor_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q    <= StLen;
                        byte_cnt_q <= 2'd0;
                        len_q      <= 32'd0;
                        word_q     <= 32'd0;
                        word_idx_q <= 32'd0;
                        xor_q      <= 8'd0;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                StLen: begin
                    if (accept) begin
                        len_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if ((len_full == 32'd0) || (len_full > 32'(MAX_WORDS))) begin
                                state_q <= StErr;
                                error_q <= 1'b1;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
                        xor_q      <= xor_q ^ byte_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= BASE_ADDR + {word_idx_q[29:0], 2'b00};
                            mem_wdata_q <= word_full;
                            word_idx_q  <= word_idx_inc;
                            if (word_idx_inc == len_q) begin
                                state_q <= StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        if (byte_data == xor_q) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
